reg_file_16x8: RTL and testbench

Sixteen-entry, 8-bit register file with one write port, two registered read ports and a sequential hardware-clear engine. It holds the datapath's general-purpose registers. Its read paths are built from the existing 16:1 byte multiplexer, so it sits directly upstream of that mux and owns the storage the mux selects from. A small FSM zeroes the array one entry per cycle on request and reports busy/done to the controller.

---
 rtl/reg_file_16x8_pkg.sv | 9 +
 rtl/eight_bit_16_1_mux.sv | 28 ++
 rtl/reg_file_16x8.sv | 87 ++++++++
 tb/tb_reg_file_16x8.sv | 110 +++++++++++
 4 files changed

// File: rtl/reg_file_16x8_pkg.sv
// reg_file_16x8_pkg: shared widths, clear value and FSM encoding for the register file
package reg_file_16x8_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH = 16;
   localparam logic [DATA_W-1:0] CLR_VAL = 8'h00;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/eight_bit_16_1_mux.sv
// eight_bit_16_1_mux: selects one of sixteen bytes a..p by {s3,s2,s1,s0}
module eight_bit_16_1_mux (
   input  logic [7:0] a, b, c, d, e, f, g, h,
   input  logic [7:0] i, j, k, l, m, n, o, p,
   input  logic       s0, s1, s2, s3,
   output logic [7:0] y
);
   // pure combinational select
   always_comb
      case ({s3, s2, s1, s0})
         4'd0:  y = a;
         4'd1:  y = b;
         4'd2:  y = c;
         4'd3:  y = d;
         4'd4:  y = e;
         4'd5:  y = f;
         4'd6:  y = g;
         4'd7:  y = h;
         4'd8:  y = i;
         4'd9:  y = j;
         4'd10: y = k;
         4'd11: y = l;
         4'd12: y = m;
         4'd13: y = n;
         4'd14: y = o;
         default: y = p;
      endcase
endmodule

// File: rtl/reg_file_16x8.sv
// reg_file_16x8: 16x8 register file, one write port, two registered read ports with bypass, sequential clear engine
module reg_file_16x8
   import reg_file_16x8_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra0,
   input  logic [ADDR_W-1:0] ra1,
   input  logic              clr_req,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1,
   output logic              busy,
   output logic              clr_done
);
   state_t            state, nxt;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_en;
   logic [ADDR_W-1:0] wr_a;
   logic [DATA_W-1:0] wr_d;
   logic [DATA_W-1:0] mux0, mux1;

   // the clear engine owns the single write port while it runs; user writes are dropped
   always_comb begin
      wr_en = (state == CLEAR) || we;
      wr_a  = (state == CLEAR) ? cnt : wa;
      wr_d  = (state == CLEAR) ? CLR_VAL : wd;
   end

   // storage array
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int x = 0; x < DEPTH; x++) mem[x] <= '0;
      else if (wr_en)
         mem[wr_a] <= wr_d;

   // state register and clear counter; counter wraps to 0 on leaving CLEAR
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
      end

   // next state: requests while clearing are not queued
   always_comb
      nxt = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : ((cnt == LAST_ADDR) ? IDLE : CLEAR);

   // busy is a direct decode of the state flop, so it has no input-to-output path
   always_comb
      busy = (state == CLEAR);

   eight_bit_16_1_mux u_mux0 (
      .a(mem[0]),  .b(mem[1]),  .c(mem[2]),  .d(mem[3]),
      .e(mem[4]),  .f(mem[5]),  .g(mem[6]),  .h(mem[7]),
      .i(mem[8]),  .j(mem[9]),  .k(mem[10]), .l(mem[11]),
      .m(mem[12]), .n(mem[13]), .o(mem[14]), .p(mem[15]),
      .s0(ra0[0]), .s1(ra0[1]), .s2(ra0[2]), .s3(ra0[3]),
      .y(mux0)
   );

   eight_bit_16_1_mux u_mux1 (
      .a(mem[0]),  .b(mem[1]),  .c(mem[2]),  .d(mem[3]),
      .e(mem[4]),  .f(mem[5]),  .g(mem[6]),  .h(mem[7]),
      .i(mem[8]),  .j(mem[9]),  .k(mem[10]), .l(mem[11]),
      .m(mem[12]), .n(mem[13]), .o(mem[14]), .p(mem[15]),
      .s0(ra1[0]), .s1(ra1[1]), .s2(ra1[2]), .s3(ra1[3]),
      .y(mux1)
   );

   // registered reads with write-through bypass, plus the one-cycle done pulse on the last clear write
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd0      <= '0;
         rd1      <= '0;
         clr_done <= 1'b0;
      end else begin
         rd0      <= (wr_en && wr_a == ra0) ? wr_d : mux0;
         rd1      <= (wr_en && wr_a == ra1) ? wr_d : mux1;
         clr_done <= (state == CLEAR) && (cnt == LAST_ADDR);
      end
endmodule

// File: tb/tb_reg_file_16x8.sv
// tb_reg_file_16x8: scoreboard bench with an array-based reference model of the register file
module tb_reg_file_16x8;
   logic       clk = 1'b0, reset = 1'b1, we = 1'b0, clr_req = 1'b0;
   logic [3:0] wa = '0, ra0 = '0, ra1 = '0;
   logic [7:0] wd = '0;
   logic [7:0] rd0, rd1;
   logic       busy, clr_done;

   typedef struct packed {
      logic [7:0] rd0;
      logic [7:0] rd1;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m [16];
   int         left = 0;
   int         vecs = 0, errs = 0;

   always #5 clk = ~clk;

   reg_file_16x8 dut (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
      .ra0(ra0), .ra1(ra1), .clr_req(clr_req),
      .rd0(rd0), .rd1(rd1), .busy(busy), .clr_done(clr_done)
   );

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("rd0", rd0, e.rd0);
         check("rd1", rd1, e.rd1);
         check("busy", {7'b0, busy}, {7'b0, e.busy});
         check("clr_done", {7'b0, clr_done}, {7'b0, e.done});
      end
   end

   task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input logic [3:0] r0, input logic [3:0] r1, input logic c);
      logic done;
      we = w; wa = a; wd = d; ra0 = r0; ra1 = r1; clr_req = c;
      @(posedge clk);
      done = 1'b0;
      if (left > 0) begin
         m[16 - left] = 8'h00;
         left--;
         done = (left == 0);
      end else begin
         if (w) m[a] = d;
         if (c) left = 16;
      end
      q.push_back('{m[r0], m[r1], left > 0, done});
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_rd0", rd0, 8'h00);
      check("rst_rd1", rd1, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_done", {7'b0, clr_done}, 8'h00);
      for (int x = 0; x < 16; x++) m[x] = 8'h00;
      left = 0;
      q.delete();
      #1 reset = 1'b0;
   endtask

   initial begin
      do_reset();
      for (int x = 0; x < 16; x++) step(0, 0, 0, 4'(x), 4'(15 - x), 0);
      step(1, 5, 8'hA5, 0, 0, 0);
      step(1, 12, 8'h3C, 0, 0, 0);
      step(0, 0, 0, 5, 12, 0);
      step(1, 7, 8'h5A, 7, 5, 0);
      step(0, 0, 0, 7, 7, 0);
      for (int x = 0; x < 16; x++) step(1, 4'(x), 8'hFF, 4'(x), 4'(15 - x), 0);
      step(1, 9, 8'h11, 9, 9, 1);
      for (int x = 0; x < 16; x++) step(x == 2 || x == 14, 3, 8'h77, 3, 4'(x), x == 5);
      step(0, 0, 0, 3, 0, 0);
      for (int x = 0; x < 16; x++) step(0, 0, 0, 4'(x), 4'(15 - x), 0);
      for (int x = 0; x < 16; x++) step(1, 4'(x), 8'hC3, 0, 4'(x), 0);
      step(0, 0, 0, 0, 0, 1);
      repeat (8) step(0, 0, 0, 4, 15, 0);
      do_reset();
      for (int x = 0; x < 16; x++) step(0, 0, 0, 4'(x), 4'(x), 0);
      step(1, 2, 8'h42, 2, 2, 1);
      repeat (18) step(0, 0, 0, 2, 15, 0);
      for (int r = 0; r < 4; r++) begin
         repeat (150) step(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                           4'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);
         do_reset();
      end
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
